// File: rtl/serial_cmp_encoder.sv
// Digit-serial unsigned comparator: scans an operand pair MSB-first, W bits per cycle,
// and reports the relation as a 3-bit SEL code plus the mask of every SEL code that holds.
module serial_cmp_encoder #(
    parameter int N          = 8,
    parameter int W          = 1,
    parameter int EARLY_EXIT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] value1,
    input  logic [N-1:0] value2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [2:0]   out_sel,
    output logic [7:0]   out_mask,
    output logic         busy
);

    generate
        if ((W < 1) || (W > N) || ((N % W) != 0)) begin : g_badDigitWidth
            $error("serial_cmp_encoder: N (%0d) must be a whole multiple of W (%0d)", N, W);
        end
    endgenerate

    localparam int DIGITS = N / W;
    localparam int DW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DW-1:0] LAST_DIGIT = DW'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t          r_state;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic            r_gt;
    logic            r_lt;
    logic [DW-1:0]   r_d;

    logic [W-1:0]    w_digA;
    logic [W-1:0]    w_digB;
    logic            w_undecided;
    logic            w_newGt;
    logic            w_newLt;
    logic            w_exit;
    logic [2:0]      w_sel;
    logic [7:0]      w_mask;

    // Only the first differing digit decides; once a flag is set it is frozen.
    assign w_digA      = r_a[N-1 -: W];
    assign w_digB      = r_b[N-1 -: W];
    assign w_undecided = !r_gt && !r_lt;
    assign w_newGt     = r_gt || (w_undecided && (w_digA > w_digB));
    assign w_newLt     = r_lt || (w_undecided && (w_digA < w_digB));
    assign w_exit      = (r_d == LAST_DIGIT) ||
                         ((EARLY_EXIT != 0) && w_undecided && (w_digA != w_digB));

    // Mask bits: 0 never, 1 always, 2 eq, 3 ne, 4 ge, 5 le, 6 lt, 7 gt.
    always_comb begin
        w_sel  = 3'b010;
        w_mask = 8'h36;
        if (w_newGt) begin
            w_sel  = 3'b111;
            w_mask = 8'h9A;
        end else if (w_newLt) begin
            w_sel  = 3'b110;
            w_mask = 8'h6A;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_gt      <= 1'b0;
            r_lt      <= 1'b0;
            r_d       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_sel   <= 3'b000;
            out_mask  <= 8'h00;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        r_a      <= value1;
                        r_b      <= value2;
                        r_gt     <= 1'b0;
                        r_lt     <= 1'b0;
                        r_d      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        r_state  <= SCAN;
                    end
                end
                SCAN: begin
                    r_a  <= r_a << W;
                    r_b  <= r_b << W;
                    r_gt <= w_newGt;
                    r_lt <= w_newLt;
                    r_d  <= r_d + 1'b1;
                    if (w_exit) begin
                        out_valid <= 1'b1;
                        out_sel   <= w_sel;
                        out_mask  <= w_mask;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    // Result held until consumed; the next accept waits one more cycle in IDLE.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_cmp_encoder.sv
// Directed bench for serial_cmp_encoder: three instances cover early exit, full scan,
// and 4-bit digits; every expected code, mask and latency is a hand-computed constant.
module tb_serial_cmp_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       inValid0 = 1'b0, inValid1 = 1'b0, inValid2 = 1'b0;
    logic       outReady0 = 1'b0, outReady1 = 1'b0, outReady2 = 1'b0;
    logic [7:0] valueA0 = '0, valueA1 = '0, valueA2 = '0;
    logic [7:0] valueB0 = '0, valueB1 = '0, valueB2 = '0;
    logic       inReady0, inReady1, inReady2;
    logic       outValid0, outValid1, outValid2;
    logic       busy0, busy1, busy2;
    logic [2:0] outSel0, outSel1, outSel2;
    logic [7:0] outMask0, outMask1, outMask2;

    int compareCount = 0;
    int failCount    = 0;

    always #5 clk = ~clk;

    serial_cmp_encoder #(.N(8), .W(1), .EARLY_EXIT(1)) u_early (
        .clk(clk), .rst(rst), .in_valid(inValid0), .in_ready(inReady0),
        .value1(valueA0), .value2(valueB0), .out_valid(outValid0), .out_ready(outReady0),
        .out_sel(outSel0), .out_mask(outMask0), .busy(busy0));

    serial_cmp_encoder #(.N(8), .W(1), .EARLY_EXIT(0)) u_full (
        .clk(clk), .rst(rst), .in_valid(inValid1), .in_ready(inReady1),
        .value1(valueA1), .value2(valueB1), .out_valid(outValid1), .out_ready(outReady1),
        .out_sel(outSel1), .out_mask(outMask1), .busy(busy1));

    serial_cmp_encoder #(.N(8), .W(4), .EARLY_EXIT(0)) u_quad (
        .clk(clk), .rst(rst), .in_valid(inValid2), .in_ready(inReady2),
        .value1(valueA2), .value2(valueB2), .out_valid(outValid2), .out_ready(outReady2),
        .out_sel(outSel2), .out_mask(outMask2), .busy(busy2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int idx, input logic v, input logic [7:0] a,
                                 input logic [7:0] b, input logic oRdy);
        case (idx)
            0: begin inValid0 = v; valueA0 = a; valueB0 = b; outReady0 = oRdy; end
            1: begin inValid1 = v; valueA1 = a; valueB1 = b; outReady1 = oRdy; end
            default: begin inValid2 = v; valueA2 = a; valueB2 = b; outReady2 = oRdy; end
        endcase
    endtask

    task automatic sampleOutputs(input int idx, output logic ir, output logic ov,
                                 output logic bz, output logic [2:0] sel, output logic [7:0] mask);
        case (idx)
            0: begin ir = inReady0; ov = outValid0; bz = busy0; sel = outSel0; mask = outMask0; end
            1: begin ir = inReady1; ov = outValid1; bz = busy1; sel = outSel1; mask = outMask1; end
            default: begin ir = inReady2; ov = outValid2; bz = busy2; sel = outSel2; mask = outMask2; end
        endcase
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Waits for in_ready, accepts on the next edge, then scrambles the operand inputs.
    task automatic acceptOp(input int idx, input string tag, input logic [7:0] a, input logic [7:0] b);
        logic ir, ov, bz;
        logic [2:0] sel;
        logic [7:0] mask;
        int n;
        applyStimulus(idx, 1'b1, a, b, 1'b0);
        sampleOutputs(idx, ir, ov, bz, sel, mask);
        n = 0;
        while (!ir && n < 20) begin
            tick();
            sampleOutputs(idx, ir, ov, bz, sel, mask);
            n++;
        end
        if (!ir) checkOutput({tag, "_readyTimeout"}, 32'(ir), 32'd1);
        tick();
        applyStimulus(idx, 1'b0, ~a, ~b, 1'b0);
    endtask

    task automatic waitResult(input int idx, input string tag, input logic [2:0] expSel,
                              input logic [7:0] expMask, input int expLat);
        logic ir, ov, bz;
        logic [2:0] sel;
        logic [7:0] mask;
        int lat;
        lat = 1;
        sampleOutputs(idx, ir, ov, bz, sel, mask);
        while (!ov && lat < 40) begin
            tick();
            lat++;
            sampleOutputs(idx, ir, ov, bz, sel, mask);
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, "_sel"}, 32'(sel), 32'(expSel));
        checkOutput({tag, "_mask"}, 32'(mask), 32'(expMask));
    endtask

    task automatic handshake(input int idx, input string tag, input logic [2:0] expSel,
                             input logic [7:0] expMask);
        logic ir, ov, bz;
        logic [2:0] sel;
        logic [7:0] mask;
        applyStimulus(idx, 1'b0, 8'h00, 8'h00, 1'b1);
        tick();
        applyStimulus(idx, 1'b0, 8'h00, 8'h00, 1'b0);
        sampleOutputs(idx, ir, ov, bz, sel, mask);
        checkOutput({tag, "_postValid"}, 32'(ov), 32'd0);
        checkOutput({tag, "_postBusy"}, 32'(bz), 32'd0);
        checkOutput({tag, "_postReady"}, 32'(ir), 32'd1);
        checkOutput({tag, "_heldSel"}, 32'(sel), 32'(expSel));
        checkOutput({tag, "_heldMask"}, 32'(mask), 32'(expMask));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic ir, ov, bz, sawValid;
        logic [2:0] sel;
        logic [7:0] mask;

        // Reset state while rst is held
        rst = 1'b1;
        tick();
        tick();
        sampleOutputs(0, ir, ov, bz, sel, mask);
        checkOutput("rst_inReady", 32'(ir), 32'd0);
        checkOutput("rst_outValid", 32'(ov), 32'd0);
        checkOutput("rst_busy", 32'(bz), 32'd0);
        checkOutput("rst_sel", 32'(sel), 32'd0);
        checkOutput("rst_mask", 32'(mask), 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("rel_inReady0", 32'(inReady0), 32'd1);
        checkOutput("rel_inReady1", 32'(inReady1), 32'd1);
        checkOutput("rel_inReady2", 32'(inReady2), 32'd1);

        // Equal operands always scan every digit
        acceptOp(0, "eqA5", 8'hA5, 8'hA5);
        waitResult(0, "eqA5", 3'b010, 8'h36, 9);
        handshake(0, "eqA5", 3'b010, 8'h36);

        // Difference in the MSB: early exit vs full scan
        acceptOp(0, "gtEarly", 8'h80, 8'h7F);
        waitResult(0, "gtEarly", 3'b111, 8'h9A, 2);
        handshake(0, "gtEarly", 3'b111, 8'h9A);
        acceptOp(1, "gtFull", 8'h80, 8'h7F);
        waitResult(1, "gtFull", 3'b111, 8'h9A, 9);
        handshake(1, "gtFull", 3'b111, 8'h9A);

        // Difference only in the LSB, then in the middle
        acceptOp(0, "ltLsb", 8'h00, 8'h01);
        waitResult(0, "ltLsb", 3'b110, 8'h6A, 9);
        handshake(0, "ltLsb", 3'b110, 8'h6A);
        acceptOp(0, "gtMid", 8'h10, 8'h0F);
        waitResult(0, "gtMid", 3'b111, 8'h9A, 5);
        handshake(0, "gtMid", 3'b111, 8'h9A);

        // Backpressure: result held while the next operand pair waits with in_valid high
        acceptOp(0, "bp", 8'h01, 8'h02);
        waitResult(0, "bp", 3'b110, 8'h6A, 8);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1'b1, 8'(i * 37), 8'(255 - i * 11), 1'b0);
            tick();
            sampleOutputs(0, ir, ov, bz, sel, mask);
            checkOutput($sformatf("bp_holdSel%0d", i), 32'(sel), 32'd6);
            checkOutput($sformatf("bp_holdMask%0d", i), 32'(mask), 32'h6A);
            checkOutput($sformatf("bp_holdReady%0d", i), 32'(ir), 32'd0);
            checkOutput($sformatf("bp_holdValid%0d", i), 32'(ov), 32'd1);
        end
        applyStimulus(0, 1'b1, 8'hFF, 8'h00, 1'b1);
        tick();
        applyStimulus(0, 1'b1, 8'hFF, 8'h00, 1'b0);
        sampleOutputs(0, ir, ov, bz, sel, mask);
        checkOutput("bp_afterReady", 32'(ir), 32'd1);
        checkOutput("bp_afterValid", 32'(ov), 32'd0);
        tick();
        applyStimulus(0, 1'b0, 8'h00, 8'hFF, 1'b0);
        sampleOutputs(0, ir, ov, bz, sel, mask);
        checkOutput("bp_pendingBusy", 32'(bz), 32'd1);
        checkOutput("bp_pendingReady", 32'(ir), 32'd0);
        waitResult(0, "bpNext", 3'b111, 8'h9A, 2);
        handshake(0, "bpNext", 3'b111, 8'h9A);

        // Reset in cycle t+3 of a scan discards the operation
        acceptOp(0, "rstScan", 8'hFF, 8'hFF);
        tick();
        tick();
        rst = 1'b1;
        tick();
        sampleOutputs(0, ir, ov, bz, sel, mask);
        checkOutput("rstScan_valid", 32'(ov), 32'd0);
        checkOutput("rstScan_busy", 32'(bz), 32'd0);
        checkOutput("rstScan_sel", 32'(sel), 32'd0);
        checkOutput("rstScan_mask", 32'(mask), 32'd0);
        rst = 1'b0;
        sawValid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (outValid0) sawValid = 1'b1;
        end
        checkOutput("rstScan_noStale", 32'(sawValid), 32'd0);
        acceptOp(0, "afterRst", 8'h02, 8'h01);
        waitResult(0, "afterRst", 3'b111, 8'h9A, 8);
        handshake(0, "afterRst", 3'b111, 8'h9A);

        // Four-bit digits, full scan
        acceptOp(2, "quad", 8'h3C, 8'h3D);
        waitResult(2, "quad", 3'b110, 8'h6A, 3);
        handshake(2, "quad", 3'b110, 8'h6A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
